// File: rtl/plusarg_pkg.sv
// Shared types and constants for the plusarg string harness blocks.
package plusarg_pkg;

  typedef enum logic [1:0] {IDLE, SEND, TERM, FIN} state_t;

  localparam logic [7:0] CHAR_NUL = 8'h00;
  localparam logic [7:0] CHAR_LF  = 8'h0A;

  function automatic int str_bytes(input int str_w);
    return str_w / 8;
  endfunction

endpackage

// File: rtl/str_len_calc.sv
// Combinational length of a right-aligned, NUL-padded packed string:
// index of the highest nonzero byte plus one, or zero when all bytes are NUL.
module str_len_calc
  import plusarg_pkg::*;
#(
  parameter int STR_W = 256,
  parameter int LEN_W = $clog2(str_bytes(STR_W) + 1)
) (
  input  logic [STR_W-1:0] str_in,
  output logic [LEN_W-1:0] len
);

  localparam int NBYTES = str_bytes(STR_W);

  // Ascending scan so the highest nonzero byte wins.
  always_comb begin
    len = '0;
    for (int k = 0; k < NBYTES; k++) begin
      if (str_in[8*k +: 8] != CHAR_NUL) len = LEN_W'(k + 1);
    end
  end

endmodule

// File: rtl/plusarg_str_tx.sv
// Streams a packed plusarg string out one character per transfer over a
// valid/ready channel, with an optional terminator byte appended.
module plusarg_str_tx
  import plusarg_pkg::*;
#(
  parameter int         STR_W       = 256,
  parameter bit         APPEND_TERM = 1'b1,
  parameter logic [7:0] TERM_CHAR   = CHAR_LF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             load,
  input  logic [STR_W-1:0] str_in,
  output logic             busy,
  output logic             c_valid,
  input  logic             c_ready,
  output logic [7:0]       c_data,
  output logic             c_last,
  output logic             done
);

  localparam int NBYTES = str_bytes(STR_W);
  localparam int LEN_W  = $clog2(NBYTES + 1);

  state_t           state;
  logic [STR_W-1:0] shreg;
  logic [LEN_W-1:0] cnt;
  logic [LEN_W-1:0] len;
  logic [STR_W-1:0] aligned;
  logic [STR_W-1:0] shifted;

  str_len_calc #(.STR_W(STR_W), .LEN_W(LEN_W)) u_len (
    .str_in (str_in),
    .len    (len)
  );

  // The first character is parked in the top byte so the stream is a plain left shift.
  always_comb begin
    aligned = str_in << ((NBYTES - int'(len)) * 8);
    shifted = shreg << 8;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      shreg   <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      c_valid <= 1'b0;
      c_data  <= CHAR_NUL;
      c_last  <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (load) begin
            shreg <= aligned;
            cnt   <= len;
            if (len != '0) begin
              state   <= SEND;
              busy    <= 1'b1;
              c_valid <= 1'b1;
              c_data  <= aligned[STR_W-1 -: 8];
              c_last  <= !APPEND_TERM && (len == LEN_W'(1));
            end else if (APPEND_TERM) begin
              state   <= TERM;
              busy    <= 1'b1;
              c_valid <= 1'b1;
              c_data  <= TERM_CHAR;
              c_last  <= 1'b1;
            end else begin
              state <= FIN;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        SEND: begin
          if (c_ready) begin
            shreg <= shifted;
            cnt   <= cnt - LEN_W'(1);
            if (cnt == LEN_W'(1)) begin
              if (APPEND_TERM) begin
                state  <= TERM;
                c_data <= TERM_CHAR;
                c_last <= 1'b1;
              end else begin
                state   <= FIN;
                c_valid <= 1'b0;
                c_last  <= 1'b0;
                busy    <= 1'b0;
                done    <= 1'b1;
              end
            end else begin
              c_data <= shifted[STR_W-1 -: 8];
              c_last <= !APPEND_TERM && (cnt == LEN_W'(2));
            end
          end
        end
        TERM: begin
          if (c_ready) begin
            state   <= FIN;
            c_valid <= 1'b0;
            c_last  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
          end
        end
        FIN: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_plusarg_str_tx.sv
// Directed bench for plusarg_str_tx: one terminator-appending instance and
// one plain instance, checked with immediate assertions.
module tb_plusarg_str_tx;

  logic         CLK;
  logic         RST;
  logic         load;
  logic         load1;
  logic [255:0] str_in;
  logic         c_ready;

  logic       busy, c_valid, c_last, done;
  logic [7:0] c_data;
  logic       busy1, c_valid1, c_last1, done1;
  logic [7:0] c_data1;

  int checks   = 0;
  int failures = 0;

  plusarg_str_tx #(.STR_W(256), .APPEND_TERM(1'b1), .TERM_CHAR(8'h0A)) dut (
    .CLK(CLK), .RST(RST), .load(load), .str_in(str_in), .busy(busy),
    .c_valid(c_valid), .c_ready(c_ready), .c_data(c_data), .c_last(c_last), .done(done)
  );

  plusarg_str_tx #(.STR_W(256), .APPEND_TERM(1'b0), .TERM_CHAR(8'h0A)) dut1 (
    .CLK(CLK), .RST(RST), .load(load1), .str_in(str_in), .busy(busy1),
    .c_valid(c_valid1), .c_ready(c_ready), .c_data(c_data1), .c_last(c_last1), .done(done1)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [255:0] s);
    str_in  = s;
    load    = 1'b1;
    c_ready = 1'b1;
    step();
    load = 1'b0;
  endtask

  // Entered at the sample point right after the load edge; ends one cycle after done.
  task automatic collectStream(input string tag, input logic [7:0] exp[$], input bit toggle,
                               output int validCycles);
    int         idx;
    int         cycles;
    bit         prevStall;
    logic [9:0] prevWord;
    logic       rdy;
    idx = 0; cycles = 0; prevStall = 0; prevWord = '0; validCycles = 0;
    checkOutput({tag, "_first_valid"}, c_valid, 1);
    while (idx < exp.size() && cycles < 200) begin
      rdy = toggle ? (cycles % 2 == 0) : 1'b1;
      c_ready = rdy;
      if (prevStall) checkOutput({tag, "_stall_hold"}, {c_valid, c_last, c_data}, prevWord);
      prevStall = 0;
      if (c_valid) begin
        validCycles++;
        if (rdy) begin
          checkOutput({tag, "_byte"}, c_data, exp[idx]);
          checkOutput({tag, "_last"}, c_last, (idx == exp.size() - 1));
          checkOutput({tag, "_busy"}, busy, 1);
          idx++;
        end else begin
          prevStall = 1;
          prevWord  = {c_valid, c_last, c_data};
        end
      end
      step();
      load = 1'b0;
      cycles++;
    end
    checkOutput({tag, "_count"}, idx, exp.size());
    c_ready = 1'b1;
    checkOutput({tag, "_done"}, done, 1);
    checkOutput({tag, "_busy_fall"}, busy, 0);
    checkOutput({tag, "_valid_fall"}, c_valid, 0);
    step();
    checkOutput({tag, "_done_once"}, done, 0);
  endtask

  initial begin
    logic [7:0]   q[$];
    logic [255:0] s;
    int           vc;

    RST = 1'b1; load = 1'b0; load1 = 1'b0; c_ready = 1'b0; str_in = '0;
    step();
    step();
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_valid", c_valid, 0);
    checkOutput("rst_data", c_data, 8'h00);
    checkOutput("rst_last", c_last, 0);
    checkOutput("rst_done", done, 0);
    RST = 1'b0;
    step();

    // "ab" with terminator at full throughput
    applyStimulus(256'h6162);
    q = {8'h61, 8'h62, 8'h0A};
    collectStream("ab", q, 1'b0, vc);
    checkOutput("ab_valid_cycles", vc, 3);

    // empty string: lone terminator
    applyStimulus('0);
    q = {8'h0A};
    collectStream("empty", q, 1'b0, vc);

    // empty string without terminator: done next cycle, nothing emitted
    str_in = '0; load1 = 1'b1;
    step();
    load1 = 1'b0;
    checkOutput("noterm_empty_valid", c_valid1, 0);
    checkOutput("noterm_empty_done", done1, 1);
    checkOutput("noterm_empty_busy", busy1, 0);
    step();
    checkOutput("noterm_empty_done_once", done1, 0);

    // "ab" without terminator: c_last on the final string byte
    str_in = 256'h6162; load1 = 1'b1; c_ready = 1'b1;
    step();
    load1 = 1'b0;
    checkOutput("noterm_b0", {c_valid1, c_last1, c_data1}, {2'b10, 8'h61});
    step();
    checkOutput("noterm_b1", {c_valid1, c_last1, c_data1}, {2'b11, 8'h62});
    step();
    checkOutput("noterm_done", {done1, busy1, c_valid1}, 3'b100);

    // full 32-char string with c_ready toggling
    s = '0; q = {};
    for (int i = 0; i < 32; i++) begin
      s[8*(31-i) +: 8] = 8'h21 + 8'(i);
      q.push_back(8'h21 + 8'(i));
    end
    q.push_back(8'h0A);
    applyStimulus(s);
    collectStream("full", q, 1'b1, vc);
    checkOutput("full_valid_cycles", vc, 65);

    // embedded NUL is emitted
    applyStimulus(256'h410042);
    q = {8'h41, 8'h00, 8'h42, 8'h0A};
    collectStream("nul", q, 1'b0, vc);

    // load while busy is ignored; reload right after done is accepted
    applyStimulus(256'h78797A);
    str_in = 256'h5151; load = 1'b1;
    q = {8'h78, 8'h79, 8'h7A, 8'h0A};
    collectStream("busyload", q, 1'b0, vc);
    applyStimulus(256'h5151);
    q = {8'h51, 8'h51, 8'h0A};
    collectStream("reload", q, 1'b0, vc);

    // reset after the third transfer of a 10-char string
    s = 256'h30313233343536373839;
    applyStimulus(s);
    step();
    step();
    step();
    checkOutput("rst_mid_pre", c_data, 8'h33);
    RST = 1'b1;
    step();
    RST = 1'b0;
    checkOutput("rst_mid_valid", c_valid, 0);
    checkOutput("rst_mid_busy", busy, 0);
    checkOutput("rst_mid_done", done, 0);
    checkOutput("rst_mid_data", c_data, 8'h00);
    step();
    checkOutput("rst_mid_no_done", done, 0);
    applyStimulus(s);
    q = {8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h0A};
    collectStream("restart", q, 1'b0, vc);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
